pmem_burst_responder: RTL and testbench
=======================================

# pmem_burst_responder

Synthesizable responder for the 64-bit, 4-beat physical-memory burst interface that the `mp4` core drives through its `pmem_*` ports. It sits on the memory side of that interface and takes the place of the behavioural burst-memory model. It holds a line-addressed backing store, applies a fixed, configurable access latency, and then streams or absorbs a 256-bit cacheline as four 64-bit beats. It is the responder to the cache-side line adaptor that acts as initiator.

## Interface
Parameters:
- `LATENCY`, default 4: number of idle wait cycles between request acceptance and the first beat. Legal range is 0 to 255.
- `IDX_BITS`, default 8: line index width. The store holds 2^IDX_BITS lines of 256 bits.

Ports:
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `pmem_read`  in  1: read request, held high by the initiator for the whole burst.
- `pmem_write`  in  1: write request, held high by the initiator for the whole burst.
- `pmem_address`  in  32: byte address of the line. Bits [4:0] are ignored. Bits [5+:IDX_BITS] select the line. Upper bits are ignored, so the store aliases.
- `pmem_wdata`  in  64: write beat data.
- `pmem_resp`  out  1: beat strobe. High for exactly 4 consecutive cycles per burst.
- `pmem_rdata`  out  64: read beat data. Valid only while `pmem_resp` is high during a read.
- `proto_err`  out  1: sticky protocol-violation flag. Tied to 0 unless the feature in Configuration is compiled in.

## Operation
States:
- IDLE
- WAIT
- RBURST
- WBURST
- DONE

Transitions:
- **IDLE**
  - If `pmem_read` or `pmem_write` is high at an edge, the request is accepted.
  - On acceptance, latch the index, the direction, and (for reads) the full 256-bit line into `line_buf`.
  - Load the latency counter with `LATENCY`.
  - Go to WAIT, or go straight to the burst state if `LATENCY`=0.
- **Simultaneous read and write:** read wins.
- **WAIT:** decrement the counter each cycle. At 0, go to RBURST or WBURST, with beat counter = 0.
- **RBURST**
  - `pmem_resp`=1.
  - `pmem_rdata` = `line_buf[64*beat +: 64]`.
  - Beat increments every cycle. After beat 3, go to DONE.
- **WBURST**
  - `pmem_resp`=1.
  - Each cycle, `pmem_wdata` is written to `store[idx][64*beat +: 64]`.
  - After beat 3, go to DONE.
  - Every write beat is committed as it arrives. An aborted burst leaves the beats already written in the store.
- **DONE**
  - One cycle with `pmem_resp`=0.
  - Requests are ignored in this cycle, so a request still held high does not retrigger.
  - Go to IDLE.

Other rules:
- Beat order: beat k carries line bits [64k+63:64k]. The beat counter is 2 bits wide and wraps only through the state change.
- Read-after-write: a read accepted after a write's DONE cycle returns the new data.
- Inputs during WAIT and bursts: request level and address are not re-sampled. The latched index and direction govern the whole transaction.

## Timing
- Reset: state = IDLE, `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0, counters = 0.
  - Store contents are not cleared by `rst`. They are undefined at power-up.
- `rst` mid-transaction: the machine returns to IDLE on that edge and the burst is abandoned.
- Request high in cycle 0 gives `pmem_resp` high in cycles `LATENCY+1` through `LATENCY+4`.
- Back-to-back requests: minimum spacing between the start of one burst and the acceptance of the next is `LATENCY`+6 cycles (accept, `LATENCY` wait, 4 beats, DONE).
- Output sources:
  - `pmem_resp` decodes directly from registered state.
  - `pmem_rdata` is a mux of registered `line_buf`, forced to 0 outside RBURST.

## Configuration
- Macro `PMEM_PROTO_CHECK_EN` defined: `proto_err` is set, and stays set until `rst`, on any of these violations:
  - read and write high together in IDLE;
  - the request level for the active direction dropping before beat 3 in WAIT, RBURST or WBURST;
  - `pmem_address[31:5]` changing during WAIT, RBURST or WBURST.
  - Functional behaviour is unchanged.
- Macro not defined: `proto_err` is constant 0 and no checker logic is built.

## Structure
- Package `pmem_pkg` holds:
  - the state enum `pmem_state_t`;
  - `PMEM_BEATS`=4;
  - `PMEM_BEAT_W`=64;
  - `PMEM_LINE_W`=256;
  - the typedef `pmem_line_t`.
- Sub-module `pmem_line_ram`:
  - `2^IDX_BITS` × 256-bit array;
  - synchronous 64-bit beat write, with index and beat select;
  - asynchronous 256-bit line read, used to load `line_buf` on acceptance.
- The FSM, counters and checker live in the top module.

## Test plan
1. **Write then read, `LATENCY`=4.**
   - Stimulus: write to 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then a read to 0x0000_0040.
   - Required: `pmem_resp` high in cycles 5–8 of each transaction. The read returns the four beats in order.
2. **`LATENCY`=0.**
   - Stimulus: read request in cycle 0.
   - Required: `pmem_resp` high in cycles 1–4, low in cycle 5 (DONE) even though `pmem_read` is still high. The next acceptance occurs in cycle 6.
3. **Aliasing, `IDX_BITS`=8.**
   - Stimulus: write to 0x0000_2040, then read 0x0000_0040.
   - Required: the read returns the written line. Address bits [4:0]=0x1F change nothing.
4. **Simultaneous requests.**
   - Stimulus: read and write high together.
   - Required: a read burst is performed. `proto_err`=1 with `PMEM_PROTO_CHECK_EN`, 0 without.
5. **Reset mid-burst.**
   - Stimulus: assert `rst` on beat 2 of a write.
   - Required: next cycle `pmem_resp`=0 and state is IDLE. A subsequent read shows beats 0–1 new and beats 2–3 old.
6. **Checker.**
   - Stimulus: drop `pmem_read` during WAIT.
   - Required: with `PMEM_PROTO_CHECK_EN`, `proto_err` rises and stays high until `rst`. The burst still completes with 4 `pmem_resp` cycles.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types and widths for the pmem burst responder.
package pmem_pkg;

    localparam int unsigned PMEM_BEATS      = 4;
    localparam int unsigned PMEM_BEAT_W     = 64;
    localparam int unsigned PMEM_LINE_W     = 256;
    localparam int unsigned PMEM_ADDR_W     = 32;
    localparam int unsigned PMEM_OFS_W      = 5;
    localparam int unsigned PMEM_BEAT_IDX_W = 2;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;
    typedef logic [PMEM_BEAT_W-1:0] pmem_beat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RBURST,
        ST_WBURST,
        ST_DONE
    } pmem_state_t;

endpackage

// File: rtl/pmem_burst_responder_if.sv
// 64-bit, 4-beat pmem burst bus; master is the cache-side initiator.
interface pmem_burst_responder_if;
    import pmem_pkg::*;

    logic                   pmem_read;
    logic                   pmem_write;
    logic [PMEM_ADDR_W-1:0] pmem_address;
    pmem_beat_t             pmem_wdata;
    logic                   pmem_resp;
    pmem_beat_t             pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );

endinterface

// File: rtl/pmem_line_ram.sv
// Line store: synchronous 64-bit beat write, asynchronous full-line read.
module pmem_line_ram
    import pmem_pkg::*;
#(
    parameter int unsigned IDX_BITS = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [IDX_BITS-1:0]        i_widx,
    input  logic [PMEM_BEAT_IDX_W-1:0] i_wbeat,
    input  pmem_beat_t                 i_wdata,
    input  logic [IDX_BITS-1:0]        i_ridx,
    output pmem_line_t                 o_rline
);

    localparam int unsigned DEPTH = 1 << IDX_BITS;

    pmem_line_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx][{i_wbeat, 6'd0} +: PMEM_BEAT_W] <= i_wdata;
        end
    end

    assign o_rline = r_mem[i_ridx];

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the 4-beat pmem burst bus with fixed access latency.
// Optional protocol checker compiled in with `define PMEM_PROTO_CHECK_EN.
module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned IDX_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pmem_burst_responder_if.slave  bus,
    output logic                   proto_err
);

    localparam int unsigned     CNT_W = 8;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    pmem_state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [PMEM_BEAT_IDX_W-1:0] r_beat, w_beat_nxt;
    logic [IDX_BITS-1:0]        r_idx;
    logic                       r_is_read;
    pmem_line_t                 r_line_buf;
    pmem_line_t                 w_ram_line;
    logic                       w_req;
    logic                       w_accept;
    logic                       w_we;
    logic [IDX_BITS-1:0]        w_req_idx;
    logic                       w_unused;

    assign w_req     = bus.pmem_read | bus.pmem_write;
    assign w_accept  = (r_state == ST_IDLE) && w_req;
    assign w_req_idx = bus.pmem_address[PMEM_OFS_W +: IDX_BITS];
    // Reset wins over a write beat landing on the same edge.
    assign w_we      = (r_state == ST_WBURST) && !rst;
    assign w_unused  = ^bus.pmem_address;

    pmem_line_ram #(.IDX_BITS(IDX_BITS)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wbeat (r_beat),
        .i_wdata (bus.pmem_wdata),
        .i_ridx  (w_req_idx),
        .o_rline (w_ram_line)
    );

    // Next-state logic; read wins a simultaneous request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_nxt  = LAT_C;
                    w_beat_nxt = '0;
                    if (LAT_C == '0) begin
                        w_state_nxt = bus.pmem_read ? ST_RBURST : ST_WBURST;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = r_is_read ? ST_RBURST : ST_WBURST;
                end
            end
            ST_RBURST, ST_WBURST: begin
                w_beat_nxt = r_beat + PMEM_BEAT_IDX_W'(1);
                if (r_beat == PMEM_BEAT_IDX_W'(3)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_idx      <= '0;
            r_is_read  <= 1'b0;
            r_line_buf <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_idx     <= w_req_idx;
                r_is_read <= bus.pmem_read;
                if (bus.pmem_read) begin
                    r_line_buf <= w_ram_line;
                end
            end
        end
    end

    assign bus.pmem_resp  = (r_state == ST_RBURST) || (r_state == ST_WBURST);
    assign bus.pmem_rdata = (r_state == ST_RBURST) ?
                            r_line_buf[{r_beat, 6'd0} +: PMEM_BEAT_W] : '0;

`ifdef PMEM_PROTO_CHECK_EN
    logic [PMEM_ADDR_W-PMEM_OFS_W-1:0] r_addr_hi;
    logic                              r_proto_err;
    logic                              w_level;
    logic                              w_addr_moved;
    logic                              w_viol;

    assign w_level      = r_is_read ? bus.pmem_read : bus.pmem_write;
    assign w_addr_moved = bus.pmem_address[PMEM_ADDR_W-1:PMEM_OFS_W] != r_addr_hi;

    // Violations: dual request, early drop of the active request, line address drift.
    always_comb begin
        w_viol = 1'b0;
        case (r_state)
            ST_IDLE:   w_viol = bus.pmem_read & bus.pmem_write;
            ST_WAIT:   w_viol = !w_level || w_addr_moved;
            ST_RBURST,
            ST_WBURST: w_viol = (!w_level && (r_beat != PMEM_BEAT_IDX_W'(3))) || w_addr_moved;
            default:   w_viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hi   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_hi <= bus.pmem_address[PMEM_ADDR_W-1:PMEM_OFS_W];
            end
            if (w_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random traffic vs line model.
module tb_pmem_burst_responder;

    localparam int LAT    = 4;
    localparam int NC     = LAT + 6;
    localparam logic [15:0] EXP_RESP_A = 16'h01E0;   // cycles 5..8 after request
`ifdef PMEM_PROTO_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        bit          rst_first;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [255:0] wline;
        int          drop_c;
        int          mod_c;
        logic [31:0] mod_addr;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_err, b_err;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_err_a = 1'b0;
    logic [255:0] model [int];

    pmem_burst_responder_if a_if ();
    pmem_burst_responder_if b_if ();

    pmem_burst_responder #(.LATENCY(LAT), .IDX_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .proto_err(a_err));
    pmem_burst_responder #(.LATENCY(0), .IDX_BITS(8)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .proto_err(b_err));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rs, bit rd, bit wr, logic [31:0] addr, logic [255:0] wl,
                                int drop_c, int mod_c, logic [31:0] mod_addr, bit err);
        vec_t v;
        v.rst_first = rs; v.rd = rd; v.wr = wr; v.addr = addr; v.wline = wl;
        v.drop_c = drop_c; v.mod_c = mod_c; v.mod_addr = mod_addr; v.exp_err = err;
        return v;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_if.pmem_read = 1'b0; a_if.pmem_write = 1'b0;
        b_if.pmem_read = 1'b0; b_if.pmem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction on dut_a: request in cycle 0, observe cycles 1..NC.
    task automatic txn(input vec_t v, output logic [255:0] rl, output logic [15:0] rp,
                       output logic [63:0] rz);
        rl = '0; rp = '0; rz = '0;
        @(negedge clk);
        a_if.pmem_read = v.rd; a_if.pmem_write = v.wr;
        a_if.pmem_address = v.addr; a_if.pmem_wdata = '0;
        for (int c = 1; c <= NC; c++) begin
            @(negedge clk);
            rp[c] = a_if.pmem_resp;
            if (v.rd && c >= LAT + 1 && c <= LAT + 4) rl[64*(c-LAT-1) +: 64] = a_if.pmem_rdata;
            else rz = rz | a_if.pmem_rdata;
            if (c >= LAT + 1 && c <= LAT + 4) a_if.pmem_wdata = v.wline[64*(c-LAT-1) +: 64];
            else a_if.pmem_wdata = '0;
            if (c == v.drop_c || c == NC) begin
                a_if.pmem_read = 1'b0; a_if.pmem_write = 1'b0;
            end
            if (c == v.mod_c) a_if.pmem_address = v.mod_addr;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [255:0] rl;
        logic [15:0]  rp;
        logic [63:0]  rz;
        int           idx;
        if (v.rst_first) begin
            do_reset();
            exp_err_a = 1'b0;
        end
        idx = int'((v.addr >> 5) % 256);
        txn(v, rl, rp, rz);
        chk({tag, " resp"}, 256'(rp), 256'(EXP_RESP_A));
        chk({tag, " rdata_outside"}, 256'(rz), 256'd0);
        if (v.rd) chk({tag, " rline"}, rl, model[idx]);
        else if (v.wr) model[idx] = v.wline;
        if (CHK && v.exp_err) exp_err_a = 1'b1;
        chk({tag, " proto_err"}, 256'(a_err), 256'(exp_err_a));
    endtask

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L2 = {64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0002,
                                   64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] L3 = {64'h0F0F_1234_5678_9ABC, 64'hF0F0_DEAD_BEEF_0001,
                                   64'h5A5A_C3C3_9696_0002, 64'hA5A5_3C3C_6969_0003};
    localparam logic [255:0] L4 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                   64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    localparam logic [255:0] L5 = {64'hBEEF_0000_0000_0044, 64'hBEEF_0000_0000_0033,
                                   64'hBEEF_0000_0000_0022, 64'hBEEF_0000_0000_0011};

    initial begin
        vec_t         tv [10];
        vec_t         v;
        logic [15:0]  rp;
        logic [255:0] rl, rb;
        int           mode, idx;

        a_if.pmem_read = 0; a_if.pmem_write = 0; a_if.pmem_address = '0; a_if.pmem_wdata = '0;
        b_if.pmem_read = 0; b_if.pmem_write = 0; b_if.pmem_address = '0; b_if.pmem_wdata = '0;

        tv[0] = mk(0, 0, 1, 32'h0000_0040, L1, -1, -1, '0, 0);
        tv[1] = mk(0, 1, 0, 32'h0000_0040, '0, -1, -1, '0, 0);
        tv[2] = mk(0, 0, 1, 32'h0000_2040, L2, -1, -1, '0, 0);   // aliases index 2
        tv[3] = mk(0, 1, 0, 32'h0000_005F, '0, -1, -1, '0, 0);
        tv[4] = mk(0, 1, 1, 32'h0000_0040, L3, -1, -1, '0, 1);   // read wins
        tv[5] = mk(1, 1, 0, 32'h0000_0040, '0,  2, -1, '0, 1);   // drop in WAIT
        tv[6] = mk(1, 1, 0, 32'h0000_0040, '0, -1,  6, 32'h0000_1040, 1);
        tv[7] = mk(1, 0, 1, 32'h0000_0060, L3, -1,  3, 32'h0000_007F, 0);
        tv[8] = mk(0, 1, 0, 32'h0000_0060, '0, -1, -1, '0, 0);
        tv[9] = mk(0, 0, 1, 32'h0000_0040, L4, -1, -1, '0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset a_resp",  256'(a_if.pmem_resp),  256'd0);
        chk("reset a_rdata", 256'(a_if.pmem_rdata), 256'd0);
        chk("reset a_err",   256'(a_err),           256'd0);
        chk("reset b_resp",  256'(b_if.pmem_resp),  256'd0);
        chk("reset b_err",   256'(b_err),           256'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tv[i], $sformatf("row%0d", i));

        // Reset during write beat 2: beats 0-1 committed, 2-3 keep old data
        @(negedge clk);
        a_if.pmem_write = 1'b1; a_if.pmem_address = 32'h0000_0040;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (c >= LAT + 1) a_if.pmem_wdata = L5[64*(c-LAT-1) +: 64];
            if (c == LAT + 3) rst = 1'b1;
        end
        @(negedge clk);
        chk("rstmid resp",  256'(a_if.pmem_resp),  256'd0);
        chk("rstmid rdata", 256'(a_if.pmem_rdata), 256'd0);
        chk("rstmid err",   256'(a_err),           256'd0);
        rst = 1'b0; a_if.pmem_write = 1'b0; a_if.pmem_wdata = '0;
        exp_err_a = 1'b0;
        model[2] = {model[2][255:128], L5[127:0]};
        run_vec(mk(0, 1, 0, 32'h0000_0040, '0, -1, -1, '0, 0), "rstmid_read");

        // LATENCY=0: write, then read held through DONE and the following IDLE
        rb = rand_line();
        @(negedge clk);
        b_if.pmem_write = 1'b1; b_if.pmem_address = 32'h0000_0080;
        rp = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rp[c] = b_if.pmem_resp;
            b_if.pmem_wdata = (c <= 4) ? rb[64*(c-1) +: 64] : 64'd0;
            if (c == 6) b_if.pmem_write = 1'b0;
        end
        chk("lat0 write resp", 256'(rp), 256'(16'h001E));
        @(negedge clk);
        b_if.pmem_read = 1'b1;
        rp = '0; rl = '0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            rp[c] = b_if.pmem_resp;
            if (c >= 1 && c <= 4) rl[64*(c-1) +: 64] = b_if.pmem_rdata;
            if (c >= 7 && c <= 10) chk($sformatf("lat0 reread beat%0d", c - 7),
                                       256'(b_if.pmem_rdata), 256'(rb[64*(c-7) +: 64]));
            if (c == 11) b_if.pmem_read = 1'b0;
        end
        chk("lat0 read resp", 256'(rp), 256'(16'h079E));
        chk("lat0 read line", rl, rb);
        chk("lat0 err", 256'(b_err), 256'd0);

        // Random traffic against the line model
        do_reset();
        exp_err_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_vec(mk(0, 0, 1, 32'(i) << 5, rand_line(), -1, -1, '0, 0),
                    $sformatf("pre%0d", i));
        end
        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 4);
            idx  = $urandom_range(0, 7);
            v = mk(0, mode != 2, mode >= 2, ($urandom() & ~32'h0000_1FE0) | (32'(idx) << 5),
                   rand_line(), -1, -1, '0, mode == 3);
            if (mode == 4) v.wr = 1'b0;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
